// File: rtl/rom_port_arbiter_pkg.sv
// rom_arb_pkg: shared types and defaults for the ROM port arbiter.
//   state_t    - arbiter FSM states
//   req_id_t   - requester identifiers (download writer plus three readers)
//   DEF_*_BASE - default SDRAM word bases of the three ROM regions
package rom_arb_pkg;

    localparam logic [22:0] DEF_CPU1_BASE = 23'h000000;
    localparam logic [22:0] DEF_CPU2_BASE = 23'h004000;
    localparam logic [22:0] DEF_SP_BASE   = 23'h008000;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        SP_LO,
        SP_HI
    } state_t;

    typedef enum logic [1:0] {
        REQ_DL,
        REQ_CPU1,
        REQ_CPU2,
        REQ_SP
    } req_id_t;

endpackage

// File: rtl/rom_port_arbiter_if.sv
// rom_port_arbiter_if: downstream SDRAM command bus.
//   mem_req/mem_we/mem_addr/mem_ds/mem_d - command issued by the arbiter
//   mem_ack/mem_q                        - one-cycle completion pulse and read data
//   master: arbiter side, slave: memory controller side.
interface rom_port_arbiter_if;
    logic        mem_req;
    logic        mem_we;
    logic [22:0] mem_addr;
    logic [1:0]  mem_ds;
    logic [15:0] mem_d;
    logic        mem_ack;
    logic [15:0] mem_q;

    modport master (
        output mem_req, mem_we, mem_addr, mem_ds, mem_d,
        input  mem_ack, mem_q
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_ds, mem_d,
        output mem_ack, mem_q
    );
endinterface

// File: rtl/rom_port_arbiter_rr_pick.sv
// rr_pick: 3-way round-robin selector, purely combinational.
//   req - request vector (bit 0 cpu1, bit 1 cpu2, bit 2 sp)
//   ptr - index (0..2) of the requester with highest priority this round
//   gnt - one-hot grant, zero when nothing requests
module rr_pick (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] gnt
);

    logic       found;
    logic [2:0] sum;
    logic [1:0] idx;

    // Scan starting at ptr, wrapping modulo 3; first requester wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < 3; k++) begin
            sum = {1'b0, ptr} + 3'(k);
            idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one SDRAM port between a ROM download writer and
// three cached ROM readers (main CPU, sound CPU, 32-bit sprite fetch).
//   clk_mem, reset_n            - clock, synchronous active-low reset
//   dl_active/dl_wr/dl_addr/dl_data, dl_overflow - byte download path
//   cpu1_addr/cpu1_q/cpu1_valid - main CPU word reader
//   cpu2_addr/cpu2_q/cpu2_valid - sound CPU word reader
//   sp_addr/sp_q/sp_valid       - sprite reader, two SDRAM words per fetch
//   mem                         - SDRAM command bus (master side)
// Each reader keeps a one-entry tag; valid is tag hit against the live address.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter logic [22:0] CPU1_BASE = DEF_CPU1_BASE,
    parameter logic [22:0] CPU2_BASE = DEF_CPU2_BASE,
    parameter logic [22:0] SP_BASE   = DEF_SP_BASE
) (
    input  logic                clk_mem,
    input  logic                reset_n,
    input  logic                dl_active,
    input  logic                dl_wr,
    input  logic [23:0]         dl_addr,
    input  logic [7:0]          dl_data,
    output logic                dl_overflow,
    input  logic [14:0]         cpu1_addr,
    output logic [15:0]         cpu1_q,
    output logic                cpu1_valid,
    input  logic [12:0]         cpu2_addr,
    output logic [15:0]         cpu2_q,
    output logic                cpu2_valid,
    input  logic [14:0]         sp_addr,
    output logic [31:0]         sp_q,
    output logic                sp_valid,
    rom_port_arbiter_if.master  mem
);

    state_t      state;
    logic        buf_full;
    logic [23:0] buf_addr;
    logic [7:0]  buf_data;
    logic [14:0] cpu1_tag;
    logic [12:0] cpu2_tag;
    logic [14:0] sp_tag;
    logic [2:0]  tag_vld;   // bit 0 cpu1, bit 1 cpu2, bit 2 sp
    logic [1:0]  rr_ptr;
    req_id_t     rd_id;
    logic [14:0] rd_addr;   // address as issued, becomes the tag on completion
    logic [15:0] sp_lo;
    logic [2:0]  need;
    logic [2:0]  gnt;
    logic        ack;
    logic        drain;

    assign cpu1_valid = tag_vld[0] && (cpu1_tag == cpu1_addr);
    assign cpu2_valid = tag_vld[1] && (cpu2_tag == cpu2_addr);
    assign sp_valid   = tag_vld[2] && (sp_tag == sp_addr);

    assign need  = {~sp_valid, ~cpu2_valid, ~cpu1_valid} & {3{~dl_active}};
    // Only an ack against a live command counts; stray pulses are dropped.
    assign ack   = mem.mem_req && mem.mem_ack;
    assign drain = (state == WR) && ack;

    rr_pick u_rr_pick (
        .req (need),
        .ptr (rr_ptr),
        .gnt (gnt)
    );

    always_ff @(posedge clk_mem) begin
        if (!reset_n) begin
            state        <= IDLE;
            mem.mem_req  <= 1'b0;
            mem.mem_we   <= 1'b0;
            mem.mem_addr <= '0;
            mem.mem_ds   <= '0;
            mem.mem_d    <= '0;
            buf_full     <= 1'b0;
            buf_addr     <= '0;
            buf_data     <= '0;
            dl_overflow  <= 1'b0;
            cpu1_q       <= '0;
            cpu2_q       <= '0;
            sp_q         <= '0;
            sp_lo        <= '0;
            cpu1_tag     <= '0;
            cpu2_tag     <= '0;
            sp_tag       <= '0;
            tag_vld      <= '0;
            rr_ptr       <= 2'd0;
            rd_id        <= REQ_CPU1;
            rd_addr      <= '0;
        end else begin
            // One-entry download buffer; the slot frees on the write's ack,
            // and a byte arriving that same cycle may take it.
            if (drain)
                buf_full <= 1'b0;
            if (dl_active && dl_wr) begin
                if (!buf_full || drain) begin
                    buf_full <= 1'b1;
                    buf_addr <= dl_addr;
                    buf_data <= dl_data;
                end else begin
                    dl_overflow <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (buf_full) begin
                        mem.mem_req  <= 1'b1;
                        mem.mem_we   <= 1'b1;
                        mem.mem_addr <= buf_addr[23:1];
                        mem.mem_ds   <= {buf_addr[0], ~buf_addr[0]};
                        mem.mem_d    <= {buf_data, buf_data};
                        state        <= WR;
                    end else if (|gnt) begin
                        mem.mem_req <= 1'b1;
                        mem.mem_we  <= 1'b0;
                        mem.mem_ds  <= 2'b11;
                        if (gnt[0]) begin
                            rd_id        <= REQ_CPU1;
                            rd_addr      <= cpu1_addr;
                            mem.mem_addr <= CPU1_BASE + {8'b0, cpu1_addr};
                            state        <= RD;
                        end else if (gnt[1]) begin
                            rd_id        <= REQ_CPU2;
                            rd_addr      <= {2'b0, cpu2_addr};
                            mem.mem_addr <= CPU2_BASE + {10'b0, cpu2_addr};
                            state        <= RD;
                        end else begin
                            rd_id        <= REQ_SP;
                            rd_addr      <= sp_addr;
                            mem.mem_addr <= SP_BASE + {7'b0, sp_addr, 1'b0};
                            state        <= SP_LO;
                        end
                    end
                end
                WR: begin
                    if (ack) begin
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                        state       <= IDLE;
                    end
                end
                RD: begin
                    if (ack) begin
                        mem.mem_req <= 1'b0;
                        state       <= IDLE;
                        if (rd_id == REQ_CPU2) begin
                            cpu2_q     <= mem.mem_q;
                            cpu2_tag   <= rd_addr[12:0];
                            tag_vld[1] <= 1'b1;
                            rr_ptr     <= 2'd2;
                        end else begin
                            cpu1_q     <= mem.mem_q;
                            cpu1_tag   <= rd_addr;
                            tag_vld[0] <= 1'b1;
                            rr_ptr     <= 2'd1;
                        end
                    end
                end
                SP_LO: begin
                    if (ack) begin
                        mem.mem_req  <= 1'b0;
                        sp_lo        <= mem.mem_q;
                        mem.mem_addr <= mem.mem_addr + 23'd1;
                        state        <= SP_HI;
                    end
                end
                SP_HI: begin
                    // Entered with mem_req low: that cycle is the mandatory
                    // gap, then the second word is requested.
                    if (!mem.mem_req) begin
                        mem.mem_req <= 1'b1;
                    end else if (ack) begin
                        mem.mem_req <= 1'b0;
                        sp_q        <= {mem.mem_q, sp_lo};
                        sp_tag      <= rd_addr;
                        tag_vld[2]  <= 1'b1;
                        rr_ptr      <= 2'd0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Download invalidates everything, including reads landing now.
            if (dl_active)
                tag_vld <= '0;
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: directed bench for rom_port_arbiter with a small SDRAM
// model (fixed ack delay, optional hold, data = addr[15:0]^16'hC3C3 except
// word 0x10 which returns 16'hA55A).
module tb_rom_port_arbiter;

    logic        clk_mem = 1'b0;
    logic        reset_n = 1'b0;
    logic        dl_active = 1'b0;
    logic        dl_wr = 1'b0;
    logic [23:0] dl_addr = '0;
    logic [7:0]  dl_data = '0;
    logic        dl_overflow;
    logic [14:0] cpu1_addr = '0;
    logic [15:0] cpu1_q;
    logic        cpu1_valid;
    logic [12:0] cpu2_addr = '0;
    logic [15:0] cpu2_q;
    logic        cpu2_valid;
    logic [14:0] sp_addr = '0;
    logic [31:0] sp_q;
    logic        sp_valid;

    rom_port_arbiter_if mem_if ();

    rom_port_arbiter dut (
        .clk_mem     (clk_mem),
        .reset_n     (reset_n),
        .dl_active   (dl_active),
        .dl_wr       (dl_wr),
        .dl_addr     (dl_addr),
        .dl_data     (dl_data),
        .dl_overflow (dl_overflow),
        .cpu1_addr   (cpu1_addr),
        .cpu1_q      (cpu1_q),
        .cpu1_valid  (cpu1_valid),
        .cpu2_addr   (cpu2_addr),
        .cpu2_q      (cpu2_q),
        .cpu2_valid  (cpu2_valid),
        .sp_addr     (sp_addr),
        .sp_q        (sp_q),
        .sp_valid    (sp_valid),
        .mem         (mem_if.master)
    );

    always #5 clk_mem = ~clk_mem;

    // ---------------- SDRAM model ----------------
    typedef struct packed {
        logic        we;
        logic [22:0] addr;
        logic [1:0]  ds;
        logic [15:0] d;
    } cmd_t;

    cmd_t        log_q[$];
    logic        m_ack = 1'b0;
    logic [15:0] m_q = '0;
    int          ack_dly = 3;
    bit          hold = 1'b0;
    bit          inject = 1'b0;
    int          cnt = 0;

    assign mem_if.mem_ack = m_ack;
    assign mem_if.mem_q   = m_q;

    function automatic logic [15:0] mdata(input logic [22:0] a);
        return (a == 23'h000010) ? 16'hA55A : (a[15:0] ^ 16'hC3C3);
    endfunction

    always @(negedge clk_mem) begin
        if (m_ack) begin
            m_ack = 1'b0;
        end else if (inject) begin
            m_ack = 1'b1;
            m_q   = 16'hFFFF;
        end else if (mem_if.mem_req && !hold) begin
            cnt++;
            if (cnt >= ack_dly) begin
                cnt   = 0;
                m_ack = 1'b1;
                m_q   = mem_if.mem_we ? 16'h0000 : mdata(mem_if.mem_addr);
                log_q.push_back({mem_if.mem_we, mem_if.mem_addr, mem_if.mem_ds, mem_if.mem_d});
            end
        end else begin
            cnt = 0;
        end
    end

    // ---------------- checking helpers ----------------
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_mem);
        #1;
    endtask

    function automatic logic [22:0] log_addr(input int k);
        return (log_q.size() > k) ? log_q[k].addr : 23'h7FFFFF;
    endfunction

    task automatic wait_all_valid(input string nm);
        int t = 0;
        while (!(cpu1_valid && cpu2_valid && sp_valid) && t < 300) begin
            step(1);
            t++;
        end
        chk({nm, " valid timeout"}, t < 300, 1'b1);
    endtask

    task automatic wait_log(input string nm, input int n);
        int t = 0;
        while (log_q.size() < n && t < 300) begin
            step(1);
            t++;
        end
        chk({nm, " ack timeout"}, t < 300, 1'b1);
    endtask

    task automatic wait_req(input string nm);
        int t = 0;
        while (!mem_if.mem_req && t < 300) begin
            step(1);
            t++;
        end
        chk({nm, " req timeout"}, t < 300, 1'b1);
    endtask

    // ---------------- vectors ----------------
    typedef struct packed {
        logic [14:0]      a1;
        logic [12:0]      a2;
        logic [14:0]      as;
        logic [15:0]      q1;
        logic [15:0]      q2;
        logic [31:0]      qs;
        logic [3:0][22:0] c;     // expected command order, c[0] first
    } vec_t;

    vec_t vt [3];

    initial begin #400000; $display("FAIL watchdog: bench did not finish"); $fatal(1); end

    initial begin
        bit saw;
        int t;

        vt[0].a1 = 15'h0010; vt[0].a2 = 13'h0005; vt[0].as = 15'h0003;
        vt[0].q1 = 16'hA55A; vt[0].q2 = 16'h83C6; vt[0].qs = 32'h43C4_43C5;
        vt[0].c  = {23'h008007, 23'h008006, 23'h004005, 23'h000010};
        vt[1].a1 = 15'h1234; vt[1].a2 = 13'h1FFF; vt[1].as = 15'h7FFF;
        vt[1].q1 = 16'hD1F7; vt[1].q2 = 16'h9C3C; vt[1].qs = 32'hBC3C_BC3D;
        vt[1].c  = {23'h017FFF, 23'h017FFE, 23'h005FFF, 23'h001234};
        vt[2].a1 = 15'h7FFF; vt[2].a2 = 13'h0000; vt[2].as = 15'h0000;
        vt[2].q1 = 16'hBC3C; vt[2].q2 = 16'h83C3; vt[2].qs = 32'h43C2_43C3;
        vt[2].c  = {23'h008001, 23'h008000, 23'h004000, 23'h007FFF};

        cpu1_addr = vt[0].a1; cpu2_addr = vt[0].a2; sp_addr = vt[0].as;
        reset_n = 1'b0;
        step(3);
        chk("rst mem_req", mem_if.mem_req, 1'b0);
        chk("rst mem_we", mem_if.mem_we, 1'b0);
        chk("rst mem_addr", mem_if.mem_addr, 23'h0);
        chk("rst mem_ds", mem_if.mem_ds, 2'b00);
        chk("rst mem_d", mem_if.mem_d, 16'h0);
        chk("rst qs", {cpu1_q, cpu2_q, sp_q}, 64'h0);
        chk("rst valids", {cpu1_valid, cpu2_valid, sp_valid}, 3'b000);
        chk("rst overflow", dl_overflow, 1'b0);

        // Simultaneous misses on all three readers, three patterns.
        for (int i = 0; i < 3; i++) begin
            log_q.delete();
            cpu1_addr = vt[i].a1; cpu2_addr = vt[i].a2; sp_addr = vt[i].as;
            reset_n = 1'b1;
            #1;
            chk($sformatf("v%0d valids low", i), {cpu1_valid, cpu2_valid, sp_valid}, 3'b000);
            wait_all_valid($sformatf("v%0d", i));
            chk($sformatf("v%0d cpu1_q", i), cpu1_q, vt[i].q1);
            chk($sformatf("v%0d cpu2_q", i), cpu2_q, vt[i].q2);
            chk($sformatf("v%0d sp_q", i), sp_q, vt[i].qs);
            chk($sformatf("v%0d ncmd", i), log_q.size(), 4);
            for (int k = 0; k < 4; k++)
                chk($sformatf("v%0d cmd%0d addr", i, k), log_addr(k), vt[i].c[k]);
            chk($sformatf("v%0d rd we", i), (log_q.size() > 0) ? log_q[0].we : 1'b1, 1'b0);
        end

        // Sprite valid only after the second word.
        log_q.delete();
        sp_addr = 15'h0003;
        wait_log("sp lo", 1);
        chk("sp valid after lo", sp_valid, 1'b0);
        chk("sp lo addr", log_addr(0), 23'h008006);
        t = 0;
        while (!sp_valid && t < 300) begin step(1); t++; end
        chk("sp hi timeout", t < 300, 1'b1);
        chk("sp ncmd at valid", log_q.size(), 2);
        chk("sp hi addr", log_addr(1), 23'h008007);
        chk("sp_q", sp_q, 32'h43C4_43C5);

        // Address change while the read is in flight.
        log_q.delete();
        cpu1_addr = 15'h0100;
        wait_req("midflight");
        cpu1_addr = 15'h0200;
        saw = 1'b0;
        t = 0;
        while (!cpu1_valid && t < 300) begin
            if (log_q.size() < 2 && cpu1_valid) saw = 1'b1;
            step(1);
            t++;
            if (log_q.size() < 2 && cpu1_valid) saw = 1'b1;
        end
        chk("midflight timeout", t < 300, 1'b1);
        chk("midflight early valid", saw, 1'b0);
        chk("midflight cmd0", log_addr(0), 23'h000100);
        chk("midflight cmd1", log_addr(1), 23'h000200);
        chk("midflight cpu1_q", cpu1_q, 16'hC1C3);

        // Download write to an odd byte.
        log_q.delete();
        dl_active = 1'b1;
        step(1);
        chk("dl valids", {cpu1_valid, cpu2_valid, sp_valid}, 3'b000);
        dl_wr = 1'b1; dl_addr = 24'h00A001; dl_data = 8'h3C;
        step(1);
        dl_wr = 1'b0;
        wait_req("dl wr");
        chk("dl mem_we", mem_if.mem_we, 1'b1);
        chk("dl mem_addr", mem_if.mem_addr, 23'h005000);
        chk("dl mem_ds", mem_if.mem_ds, 2'b10);
        chk("dl mem_d", mem_if.mem_d, 16'h3C3C);
        wait_log("dl wr", 1);
        step(2);
        chk("dl no reads", log_q.size(), 1);

        // Back-to-back writes with the ack withheld.
        log_q.delete();
        hold = 1'b1;
        dl_wr = 1'b1; dl_addr = 24'h000100; dl_data = 8'h11;
        step(1);
        chk("ovf after first", dl_overflow, 1'b0);
        dl_addr = 24'h000101; dl_data = 8'h22;
        step(1);
        dl_wr = 1'b0;
        chk("ovf after second", dl_overflow, 1'b1);
        chk("ovf wr addr", mem_if.mem_addr, 23'h000080);
        chk("ovf wr ds", mem_if.mem_ds, 2'b01);
        chk("ovf wr d", mem_if.mem_d, 16'h1111);
        hold = 1'b0;
        wait_log("ovf wr", 1);
        step(5);
        chk("ovf sticky", dl_overflow, 1'b1);
        dl_active = 1'b0;
        wait_all_valid("refetch");
        chk("refetch cpu1_q", cpu1_q, 16'hC1C3);
        chk("refetch ncmd", log_q.size(), 5);
        chk("ovf still set", dl_overflow, 1'b1);

        // Reset mid-transaction, then a stray ack in IDLE.
        log_q.delete();
        cpu2_addr = 13'h0007;
        wait_req("rst mid");
        reset_n = 1'b0;
        step(1);
        chk("rst mid mem_req", mem_if.mem_req, 1'b0);
        chk("rst mid overflow", dl_overflow, 1'b0);
        chk("rst mid qs", {cpu1_q, cpu2_q, sp_q}, 64'h0);
        step(1);
        reset_n = 1'b1;
        inject = 1'b1;
        step(1);
        inject = 1'b0;
        step(1);
        chk("late ack cpu1_q", cpu1_q, 16'h0);
        chk("late ack valid", cpu1_valid, 1'b0);
        wait_all_valid("post rst");
        chk("post rst cpu1_q", cpu1_q, 16'hC1C3);
        chk("post rst cpu2_q", cpu2_q, 16'h83C4);
        chk("post rst sp_q", sp_q, 32'h43C4_43C5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
